// File: rtl/exc_unit.sv
// Exception sequencer: turns WB-stage exception flags and ERET into registered
// fetch redirects, CP0 entry strobes and the core reset pulse. Optional EXC_COUNT_EN adds an entry counter.
module exc_unit #(
  parameter int          RST_CYCLES   = 4,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_VEC    = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VEC      = 32'hBFC0_0180
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ERET,
  input  logic [31:0] EPC_Q,
  input  logic        INTERRUPT,
  input  logic        SYSCALL,
  input  logic        BREAK,
  input  logic        RI,
  input  logic        CPU,
  input  logic        OV,
  input  logic        IBE,
  input  logic        DBE,
  input  logic [31:0] PC_WB,
  input  logic        DELAY_SLOT,
  input  logic        INST_SUBST,
  output logic        E_ENTER,
  output logic        E_USE_VEC,
  output logic        RESET,
  output logic [31:0] VECTOR,
  output logic [31:0] EPC,
  output logic [4:0]  CAUSE
`ifdef EXC_COUNT_EN
  ,
  output logic [15:0] EXC_COUNT
`endif
);

  typedef enum logic [1:0] {RST_HOLD, RUN, FLUSH} state_t;

  localparam int CNT_MAX = (RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               req;
  logic [4:0]         win_code;
  logic [31:0]        epc_next;

  // Fixed priority: the earliest pipeline fault owns the entry.
  always_comb begin
    req      = IBE | CPU | RI | SYSCALL | BREAK | OV | DBE | INTERRUPT;
    win_code = 5'd0;
    if      (IBE)     win_code = 5'd6;
    else if (CPU)     win_code = 5'd11;
    else if (RI)      win_code = 5'd10;
    else if (SYSCALL) win_code = 5'd8;
    else if (BREAK)   win_code = 5'd9;
    else if (OV)      win_code = 5'd12;
    else if (DBE)     win_code = 5'd7;
    epc_next = DELAY_SLOT ? PC_WB - 32'd4 : PC_WB;
  end

  // NOTE: every register here updates with <= so all outputs change together one cycle after the WB flags.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      RESET     <= 1'b1;
      E_USE_VEC <= 1'b1;
      VECTOR    <= RESET_VEC;
      E_ENTER   <= 1'b0;
      EPC       <= 32'd0;
      CAUSE     <= 5'd0;
`ifdef EXC_COUNT_EN
      EXC_COUNT <= 16'd0;
`endif
    end else begin
      case (state)
        RST_HOLD: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            state     <= RUN;
            cnt       <= '0;
            RESET     <= 1'b0;
            E_USE_VEC <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          E_ENTER   <= 1'b0;
          E_USE_VEC <= 1'b0;
          cnt       <= '0;
          if (!INST_SUBST) begin
            if (req) begin
              state     <= FLUSH;
              E_ENTER   <= 1'b1;
              E_USE_VEC <= 1'b1;
              VECTOR    <= EXC_VEC;
              CAUSE     <= win_code;
              EPC       <= epc_next;
`ifdef EXC_COUNT_EN
              if (EXC_COUNT != 16'hFFFF) EXC_COUNT <= EXC_COUNT + 16'd1;
`endif
            end else if (ERET) begin
              state     <= FLUSH;
              E_USE_VEC <= 1'b1;
              VECTOR    <= EPC_Q;
            end
          end
        end

        FLUSH: begin
          E_ENTER   <= 1'b0;
          E_USE_VEC <= 1'b0;
          if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_unit.sv
// Self-checking bench for exc_unit: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a behavioural model.
module tb_exc_unit;

  localparam int          RST_CYCLES   = 4;
  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] RESET_VEC    = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC      = 32'hBFC0_0180;

  logic        CLK = 1'b0;
  logic        RESET_N, ERET, DELAY_SLOT, INST_SUBST;
  logic [31:0] EPC_Q, PC_WB;
  logic [7:0]  fl;  // priority order: IBE CPU RI SYSCALL BREAK OV DBE INTERRUPT
  logic        E_ENTER, E_USE_VEC, RESET;
  logic [31:0] VECTOR, EPC;
  logic [4:0]  CAUSE;
`ifdef EXC_COUNT_EN
  logic [15:0] EXC_COUNT;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  exc_unit #(
    .RST_CYCLES(RST_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES),
    .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ERET(ERET), .EPC_Q(EPC_Q),
    .INTERRUPT(fl[7]), .SYSCALL(fl[3]), .BREAK(fl[4]), .RI(fl[2]),
    .CPU(fl[1]), .OV(fl[5]), .IBE(fl[0]), .DBE(fl[6]),
    .PC_WB(PC_WB), .DELAY_SLOT(DELAY_SLOT), .INST_SUBST(INST_SUBST),
    .E_ENTER(E_ENTER), .E_USE_VEC(E_USE_VEC), .RESET(RESET),
    .VECTOR(VECTOR), .EPC(EPC), .CAUSE(CAUSE)
`ifdef EXC_COUNT_EN
    , .EXC_COUNT(EXC_COUNT)
`endif
  );

  // Behavioural model state
  logic        m_enter, m_use, m_reset;
  logic [31:0] m_vec, m_epc;
  logic [4:0]  m_cause;
  int          m_rst_left, m_ignore;
  int          m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] cause_of(input logic [7:0] f);
    int codes[8] = '{6, 11, 10, 8, 9, 12, 7, 0};
    for (int i = 0; i < 8; i++)
      if (f[i]) return 5'(codes[i]);
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_enter = 0; m_use = 1; m_reset = 1; m_vec = RESET_VEC;
    m_epc = 0; m_cause = 0; m_rst_left = RST_CYCLES; m_ignore = 0; m_count = 0;
  endtask

  // Effect of one clock edge given the inputs currently driven.
  task automatic model_edge();
    if (!RESET_N) return;
    if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) begin m_reset = 0; m_use = 0; end
      return;
    end
    m_enter = 0;
    m_use   = 0;
    if (m_ignore > 0) begin
      m_ignore--;
    end else if (!INST_SUBST && fl != 0) begin
      m_enter = 1; m_use = 1; m_vec = EXC_VEC;
      m_cause = cause_of(fl);
      m_epc   = DELAY_SLOT ? PC_WB - 32'd4 : PC_WB;
      m_ignore = FLUSH_CYCLES;
      if (m_count < 65535) m_count++;
    end else if (!INST_SUBST && ERET) begin
      m_use = 1; m_vec = EPC_Q;
      m_ignore = FLUSH_CYCLES;
    end
  endtask

  task automatic compare_all();
    check("e_enter", 32'(E_ENTER), 32'(m_enter));
    check("e_use_vec", 32'(E_USE_VEC), 32'(m_use));
    check("reset", 32'(RESET), 32'(m_reset));
    check("vector", VECTOR, m_vec);
    check("epc", EPC, m_epc);
    check("cause", 32'(CAUSE), 32'(m_cause));
`ifdef EXC_COUNT_EN
    check("exc_count", 32'(EXC_COUNT), 32'(m_count));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic idle();
    fl = 0; ERET = 0; INST_SUBST = 0; DELAY_SLOT = 0;
  endtask

  typedef struct {
    logic [7:0]  flags;
    logic        eret, subst, ds;
    logic [31:0] pc, epc_q;
    logic        x_enter, x_use;
    logic [31:0] x_vec;
    logic [4:0]  x_cause;
    logic [31:0] x_epc;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{8'h08, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 32'h0, 1'b1, 1'b1, EXC_VEC, 5'd8, 32'h0040_0010};
    tv[1] = '{8'hA0, 1'b0, 1'b0, 1'b1, 32'h0040_0104, 32'h0, 1'b1, 1'b1, EXC_VEC, 5'd12, 32'h0040_0100};
    tv[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 32'h0040_0500, 32'h0040_0200, 1'b0, 1'b1, 32'h0040_0200, 5'd12, 32'h0040_0100};
    tv[3] = '{8'h40, 1'b1, 1'b0, 1'b0, 32'h0040_0300, 32'h1234_5678, 1'b1, 1'b1, EXC_VEC, 5'd7, 32'h0040_0300};
    tv[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, EXC_VEC, 5'd6, 32'hFFFF_FFFC};
    tv[5] = '{8'h06, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, EXC_VEC, 5'd11, 32'h10};
    tv[6] = '{8'h0C, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, EXC_VEC, 5'd10, 32'h20};
    tv[7] = '{8'h30, 1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 1'b1, 1'b1, EXC_VEC, 5'd9, 32'h2C};
    tv[8] = '{8'h80, 1'b0, 1'b0, 1'b0, 32'h0040_0400, 32'h0, 1'b1, 1'b1, EXC_VEC, 5'd0, 32'h0040_0400};
    tv[9] = '{8'h08, 1'b1, 1'b1, 1'b0, 32'h0040_0600, 32'h0040_0700, 1'b0, 1'b0, EXC_VEC, 5'd0, 32'h0040_0400};

    RESET_N = 0; idle(); PC_WB = 0; EPC_Q = 0;
    model_reset();
    repeat (2) step();

    // Release: RESET high for cycles 0..RST_CYCLES-1, low from cycle RST_CYCLES.
    RESET_N = 1;
    #1;
    compare_all();
    check("rst_cycle0", 32'(RESET), 32'd1);
    for (int i = 1; i <= RST_CYCLES; i++) begin
      step();
      check($sformatf("rst_cycle%0d", i), 32'(RESET), (i < RST_CYCLES) ? 32'd1 : 32'd0);
      check($sformatf("rst_usevec%0d", i), 32'(E_USE_VEC), (i < RST_CYCLES) ? 32'd1 : 32'd0);
    end

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      fl = tv[i].flags; ERET = tv[i].eret; INST_SUBST = tv[i].subst;
      DELAY_SLOT = tv[i].ds; PC_WB = tv[i].pc; EPC_Q = tv[i].epc_q;
      step();
      check($sformatf("tv%0d_enter", i), 32'(E_ENTER), 32'(tv[i].x_enter));
      check($sformatf("tv%0d_use", i), 32'(E_USE_VEC), 32'(tv[i].x_use));
      check($sformatf("tv%0d_vector", i), VECTOR, tv[i].x_vec);
      check($sformatf("tv%0d_cause", i), 32'(CAUSE), 32'(tv[i].x_cause));
      check($sformatf("tv%0d_epc", i), EPC, tv[i].x_epc);
      idle();
      step();
      check($sformatf("tv%0d_enter_drop", i), 32'(E_ENTER), 32'd0);
      repeat (FLUSH_CYCLES) step();
    end

    // RI held: entry, FLUSH_CYCLES ignored edges, then a second entry.
    fl = 8'h04; PC_WB = 32'h0040_0800;
    for (int i = 1; i <= FLUSH_CYCLES + 2; i++) begin
      step();
      check($sformatf("ri_hold%0d", i), 32'(E_ENTER),
            (i == 1 || i == FLUSH_CYCLES + 2) ? 32'd1 : 32'd0);
    end
    idle();
    repeat (FLUSH_CYCLES + 1) step();

    // RI held under instruction substitution: never taken.
    fl = 8'h04; INST_SUBST = 1; ERET = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("subst%0d", i), 32'({E_ENTER, E_USE_VEC}), 32'd0);
    end
    idle();
    step();

    // Asynchronous reset in the middle of a FLUSH.
    fl = 8'h08; PC_WB = 32'h0040_0900;
    step();
    idle();
    step();
    #2 RESET_N = 0;
    #1;
    model_reset();
    check("midflush_reset", 32'(RESET), 32'd1);
    check("midflush_vector", VECTOR, RESET_VEC);
    check("midflush_usevec", 32'(E_USE_VEC), 32'd1);
    compare_all();
`ifdef EXC_COUNT_EN
    check("count_after_reset", 32'(EXC_COUNT), 32'd0);
`endif
    step();
    RESET_N = 1;
    repeat (RST_CYCLES) step();
    check("rerun_reset_low", 32'(RESET), 32'd0);

    // Two entries after reset.
    fl = 8'h08; PC_WB = 32'h100; step(); idle(); repeat (FLUSH_CYCLES) step();
    fl = 8'h10; PC_WB = 32'h200; step(); idle(); repeat (FLUSH_CYCLES) step();
    check("two_entries_cause", 32'(CAUSE), 32'd9);
`ifdef EXC_COUNT_EN
    check("count_two", 32'(EXC_COUNT), 32'd2);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      fl         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      ERET       = ($urandom_range(0, 5) == 0);
      INST_SUBST = ($urandom_range(0, 11) == 0);
      DELAY_SLOT = 1'($urandom_range(0, 1));
      PC_WB      = $urandom;
      EPC_Q      = $urandom;
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
